// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection controller.
//   - ST_A..ST_F : state codes driven by the sequencing FSM (0..5).
//   - ST_NONE    : code that no valid phase uses; forces a reload.
//   - timer_state_e : encodings of the phase timer FSM.
//   - DEF_*      : default timing parameters.
//   - is_green / is_clear / is_valid : state-code classification helpers.
package traffic_pkg;

    localparam logic [3:0] ST_A    = 4'd0;
    localparam logic [3:0] ST_B    = 4'd1;
    localparam logic [3:0] ST_C    = 4'd2;
    localparam logic [3:0] ST_D    = 4'd3;
    localparam logic [3:0] ST_E    = 4'd4;
    localparam logic [3:0] ST_F    = 4'd5;
    localparam logic [3:0] ST_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE_BAD = 3'd0,
        S_LOAD     = 3'd1,
        S_COUNT    = 3'd2,
        S_FIRE     = 3'd3,
        S_WAIT_ACK = 3'd4
    } timer_state_e;

    localparam int DEF_TICK_DIV    = 50000000;
    localparam int DEF_CW          = 8;
    localparam int DEF_T_GREEN     = 20;
    localparam int DEF_T_CLEAR     = 5;
    localparam int DEF_T_YELLOW    = 3;
    localparam int DEF_T_SHORT     = 4;
    localparam int DEF_ACK_TIMEOUT = 8;

    // Green/walk phases A and D.
    function automatic logic is_green(input logic [3:0] s);
        return (s == ST_A) || (s == ST_D);
    endfunction

    // Pedestrian clearance phases B and E.
    function automatic logic is_clear(input logic [3:0] s);
        return (s == ST_B) || (s == ST_E);
    endfunction

    function automatic logic is_valid(input logic [3:0] s);
        return s <= ST_F;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock down to the phase timing tick.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   clear_i : restart the count at 0 on the next edge
//   tick_o  : high for one clock when the count is at TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'((TICK_DIV > 1) ? (TICK_DIV - 1) : 0);

    logic [PW-1:0] presc_q, presc_d;

    assign tick_o = (presc_q == LAST);

    always_comb begin
        presc_d = tick_o ? '0 : presc_q + PW'(1);
        if (clear_i) presc_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) presc_q <= '0;
        else       presc_q <= presc_d;
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: times each phase of the sequencing FSM and requests
// the advance to the next phase.
//   clock     : system clock
//   reset     : synchronous active-high reset
//   state     : current phase code from the sequencing FSM
//   ped_req   : pedestrian button level
//   change    : one-clock advance pulse
//   ped_flash : pedestrian red flash during clearance phases B/E
//   ped_wait  : a pedestrian request is latched
//   remaining : ticks left in the current phase
//   err       : sticky error (invalid code or missing acknowledge)
//   dbg_state : timer FSM state, for observation only
//
// Change handshake: change is a single-clock pulse. The sequencing FSM
// acknowledges by presenting a different state code; the timer then reloads
// for that code. Without an acknowledge within ACK_TIMEOUT clocks err is
// raised and the timer keeps waiting; it never pulses a second time.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int CW          = DEF_CW,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_CLEAR     = DEF_T_CLEAR,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_SHORT     = DEF_T_SHORT,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    state,
    input  logic          ped_req,
    output logic          change,
    output logic          ped_flash,
    output logic          ped_wait,
    output logic [CW-1:0] remaining,
    output logic          err,
    output logic [2:0]    dbg_state
);

    // A zero shortened green would never expire, so it is clamped like durations.
    localparam logic [CW-1:0] SHORT_CW = CW'((T_SHORT < 1) ? 1 : T_SHORT);
    localparam int ACK_LAST = (ACK_TIMEOUT > 1) ? (ACK_TIMEOUT - 1) : 0;
    localparam int AW       = (ACK_LAST > 0) ? $clog2(ACK_LAST + 1) : 1;

    timer_state_e  fsm_q, fsm_d;
    logic [3:0]    last_state_q, last_state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    logic          change_q, change_d;
    logic          ped_wait_q, ped_wait_d;
    logic          flash_q, flash_d;
    logic          err_q, err_d;
    logic          tick;
    logic          moved;
    logic          phase_active;

    function automatic logic [CW-1:0] dur_of(input logic [3:0] s);
        int d;
        if (is_green(s))      d = T_GREEN;
        else if (is_clear(s)) d = T_CLEAR;
        else                  d = T_YELLOW;
        if (d < 1) d = 1;
        return CW'(d);
    endfunction

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (fsm_q == S_LOAD),
        .tick_o  (tick)
    );

    assign moved        = (state != last_state_q);
    assign phase_active = (fsm_q == S_COUNT) || (fsm_q == S_FIRE) || (fsm_q == S_WAIT_ACK);

    always_comb begin
        fsm_d        = fsm_q;
        last_state_d = last_state_q;
        remaining_d  = remaining_q;
        ack_cnt_d    = ack_cnt_q;
        change_d     = 1'b0;
        ped_wait_d   = ped_wait_q | ped_req;
        flash_d      = flash_q;
        err_d        = err_q;

        // Flash phase follows the tick for the whole B/E phase, including
        // the pulse and acknowledge wait; the output is gated below.
        if (phase_active && tick) flash_d = ~flash_q;

        case (fsm_q)
            S_LOAD: begin
                last_state_d = state;
                if (is_valid(state)) begin
                    remaining_d = dur_of(state);
                    flash_d     = 1'b1;
                    fsm_d       = S_COUNT;
                    // Green has ended: drop the request unless the button is
                    // still held this very clock.
                    if (is_clear(state)) ped_wait_d = ped_req;
                end else begin
                    err_d = 1'b1;
                    fsm_d = S_IDLE_BAD;
                end
            end
            S_COUNT: begin
                if (moved) begin
                    fsm_d = S_LOAD;
                end else if (ped_wait_q && is_green(last_state_q) && (remaining_q > SHORT_CW)) begin
                    // Prescaler phase is left running on purpose.
                    remaining_d = SHORT_CW;
                end else if (tick) begin
                    if (remaining_q <= CW'(1)) begin
                        remaining_d = '0;
                        fsm_d       = S_FIRE;
                    end else begin
                        remaining_d = remaining_q - CW'(1);
                    end
                end
            end
            S_FIRE: begin
                change_d  = 1'b1;
                ack_cnt_d = '0;
                fsm_d     = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (moved)                              fsm_d = S_LOAD;
                else if (ack_cnt_q == AW'(ACK_LAST))    err_d = 1'b1;
                else                                    ack_cnt_d = ack_cnt_q + AW'(1);
            end
            S_IDLE_BAD: begin
                err_d = 1'b1;
                if (is_valid(state)) fsm_d = S_LOAD;
            end
            default: fsm_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q        <= S_LOAD;
            last_state_q <= ST_NONE;
            remaining_q  <= '0;
            ack_cnt_q    <= '0;
            change_q     <= 1'b0;
            ped_wait_q   <= 1'b0;
            flash_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            last_state_q <= last_state_d;
            remaining_q  <= remaining_d;
            ack_cnt_q    <= ack_cnt_d;
            change_q     <= change_d;
            ped_wait_q   <= ped_wait_d;
            flash_q      <= flash_d;
            err_q        <= err_d;
        end
    end

    assign change    = change_q;
    assign ped_wait  = ped_wait_q;
    assign remaining = remaining_q;
    assign err       = err_q;
    assign ped_flash = flash_q && phase_active && is_clear(last_state_q);
    assign dbg_state = fsm_q;

endmodule
